aibnd_clkmux_sel_ctrl: RTL and testbench

//  Glitch-free select sequencer for the aibnd 2:1 redundancy clock mux. Accepts a

---
 rtl/aibnd_clkmux_sel_ctrl_pkg.sv | 15 +
 rtl/aibnd_clkmux_sel_ctrl_if.sv | 32 +++
 rtl/aibnd_clkmux_sel_ctrl_dncnt.sv | 27 ++
 rtl/aibnd_clkmux_sel_ctrl.sv | 111 +++++++++++
 tb/tb_aibnd_clkmux_sel_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/aibnd_clkmux_sel_ctrl_pkg.sv
// Shared types and default timing constants for the aibnd clock-mux select sequencer.
package aibnd_clksel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } clksel_state_e;

  localparam int unsigned GATE_CYC_DEF   = 4;
  localparam int unsigned SETTLE_CYC_DEF = 8;
  localparam int unsigned CNT_W_DEF      = 4;

endpackage

// File: rtl/aibnd_clkmux_sel_ctrl_if.sv
// Request/status bundle between a select requester and the clock-mux select sequencer.
// Optional lock signals exist only when AIBND_CLKSEL_LOCK_EN is defined.
interface aibnd_clkmux_sel_ctrl_if;
  logic sel_req;
  logic sel_target;
  logic sel_busy;
  logic sel_done;
  logic mux_sel;
  logic clk_en;
`ifdef AIBND_CLKSEL_LOCK_EN
  logic sel_lock;
  logic sel_err;
`endif

  modport master (
    output sel_req, sel_target,
`ifdef AIBND_CLKSEL_LOCK_EN
    output sel_lock,
    input  sel_err,
`endif
    input  sel_busy, sel_done, mux_sel, clk_en
  );

  modport slave (
    input  sel_req, sel_target,
`ifdef AIBND_CLKSEL_LOCK_EN
    input  sel_lock,
    output sel_err,
`endif
    output sel_busy, sel_done, mux_sel, clk_en
  );
endinterface

// File: rtl/aibnd_clkmux_sel_ctrl_dncnt.sv
// Loadable wait counter shared by the gate and settle phases; saturates at zero.
module aibnd_clksel_dncnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/aibnd_clkmux_sel_ctrl.sv
// Glitch-free select sequencer for the aibnd 2:1 redundancy clock mux: gate, switch, settle.
// Optional request lock (sel_lock/sel_err) enabled by defining AIBND_CLKSEL_LOCK_EN.
module aibnd_clkmux_sel_ctrl
  import aibnd_clksel_pkg::*;
#(
  parameter int unsigned GATE_CYC   = GATE_CYC_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter logic        RST_SEL    = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  aibnd_clkmux_sel_ctrl_if.slave bus
);

  clksel_state_e state;
  logic          target_q;
  logic          mux_sel_q;
  logic          clk_en_q;
  logic          busy_q;
  logic          done_q;
  logic          locked;
  logic          accept;
  logic          cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic          cnt_dec;
  logic          cnt_zero;

`ifdef AIBND_CLKSEL_LOCK_EN
  logic err_q;

  assign locked      = bus.sel_lock;
  assign bus.sel_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && bus.sel_req && bus.sel_lock;
    end
  end
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    accept       = (state == IDLE) && bus.sel_req && !locked && (bus.sel_target != mux_sel_q);
    cnt_load     = accept || (state == SWITCH);
    cnt_load_val = (state == SWITCH) ? CNT_W'(SETTLE_CYC - 1) : CNT_W'(GATE_CYC - 1);
    cnt_dec      = (state == GATE) || (state == SETTLE);
  end

  aibnd_clksel_dncnt #(
    .CNT_W (CNT_W)
  ) u_dncnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Target is frozen at acceptance; requests seen outside IDLE are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target_q  <= RST_SEL;
      mux_sel_q <= RST_SEL;
      clk_en_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target_q <= bus.sel_target;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b1;
            state    <= GATE;
          end else if (bus.sel_req && !locked) begin
            done_q <= 1'b1;
          end
        end
        GATE: begin
          if (cnt_zero) state <= SWITCH;
        end
        SWITCH: begin
          mux_sel_q <= target_q;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (cnt_zero) begin
            clk_en_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mux_sel  = mux_sel_q;
  assign bus.clk_en   = clk_en_q;
  assign bus.sel_busy = busy_q;
  assign bus.sel_done = done_q;

endmodule

// File: tb/tb_aibnd_clkmux_sel_ctrl.sv
// Directed self-checking bench for aibnd_clkmux_sel_ctrl with default timing (4 gate, 8 settle).
// Lock scenario is exercised when AIBND_CLKSEL_LOCK_EN is defined.
module tb_aibnd_clkmux_sel_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned passed = 0;
  int unsigned total = 0;
  int unsigned inv_viol = 0;

  aibnd_clkmux_sel_ctrl_if bus ();

  aibnd_clkmux_sel_ctrl #(
    .GATE_CYC   (4),
    .SETTLE_CYC (8),
    .CNT_W      (4),
    .RST_SEL    (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // mux_sel may only move while the downstream clock is gated (or under reset)
  always @(bus.mux_sel) begin
    if (rst_n === 1'b1 && bus.clk_en === 1'b1) inv_viol++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.sel_req = 1'b0;
    bus.sel_target = 1'b0;
`ifdef AIBND_CLKSEL_LOCK_EN
    bus.sel_lock = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.mux_sel !== 1'b0) $display("FAIL reset_mux_sel got %b want 0", bus.mux_sel); else passed++;
    total++; if (bus.clk_en !== 1'b1) $display("FAIL reset_clk_en got %b want 1", bus.clk_en); else passed++;
    total++; if (bus.sel_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.sel_busy); else passed++;
    total++; if (bus.sel_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.sel_done); else passed++;
  endtask

  // Runs a full sequence toward tgt starting from mux_sel=from; checks every edge E0..E14.
  task automatic run_sequence(input logic from, input logic tgt, input string tag);
    logic exp_sel, exp_en, exp_busy, exp_done;
    bus.sel_req = 1'b1;
    bus.sel_target = tgt;
    step();
    bus.sel_req = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      exp_sel  = (k >= 5) ? tgt : from;
      exp_en   = (k >= 13);
      exp_busy = (k < 13);
      exp_done = (k == 13);
      total++; if (bus.mux_sel !== exp_sel) $display("FAIL %s_mux_sel E%0d got %b want %b", tag, k, bus.mux_sel, exp_sel); else passed++;
      total++; if (bus.clk_en !== exp_en) $display("FAIL %s_clk_en E%0d got %b want %b", tag, k, bus.clk_en, exp_en); else passed++;
      total++; if (bus.sel_busy !== exp_busy) $display("FAIL %s_busy E%0d got %b want %b", tag, k, bus.sel_busy, exp_busy); else passed++;
      total++; if (bus.sel_done !== exp_done) $display("FAIL %s_done E%0d got %b want %b", tag, k, bus.sel_done, exp_done); else passed++;
      if (k < 14) step();
    end
  endtask

  task automatic test_switch();
    run_sequence(1'b0, 1'b1, "switch");
  endtask

  task automatic test_noop();
    bus.sel_req = 1'b1;
    bus.sel_target = 1'b1;
    step();
    bus.sel_req = 1'b0;
    total++; if (bus.sel_done !== 1'b1) $display("FAIL noop_done got %b want 1", bus.sel_done); else passed++;
    total++; if (bus.sel_busy !== 1'b0) $display("FAIL noop_busy got %b want 0", bus.sel_busy); else passed++;
    total++; if (bus.clk_en !== 1'b1) $display("FAIL noop_clk_en got %b want 1", bus.clk_en); else passed++;
    step();
    total++; if (bus.sel_done !== 1'b0) $display("FAIL noop_done_clear got %b want 0", bus.sel_done); else passed++;
    total++; if (bus.mux_sel !== 1'b1) $display("FAIL noop_mux_sel got %b want 1", bus.mux_sel); else passed++;
  endtask

  task automatic test_ignore_while_busy();
    do_reset();
    bus.sel_req = 1'b1;
    bus.sel_target = 1'b1;
    step();
    bus.sel_req = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      bus.sel_req = (k == 8);
      bus.sel_target = (k >= 8) ? 1'b0 : 1'b1;
      step();
    end
    bus.sel_req = 1'b0;
    total++; if (bus.sel_done !== 1'b1) $display("FAIL ignore_done got %b want 1", bus.sel_done); else passed++;
    total++; if (bus.mux_sel !== 1'b1) $display("FAIL ignore_mux_sel got %b want 1", bus.mux_sel); else passed++;
    step();
    total++; if (bus.sel_busy !== 1'b0) $display("FAIL ignore_no_requeue got %b want 0", bus.sel_busy); else passed++;
    total++; if (inv_viol !== 0) $display("FAIL invariant_mux_sel_while_clk_en got %0d want 0", inv_viol); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.sel_req = 1'b1;
    bus.sel_target = 1'b1;
    step();
    bus.sel_req = 1'b0;
    repeat (13) step();
    total++; if (bus.sel_done !== 1'b1) $display("FAIL b2b_first_done got %b want 1", bus.sel_done); else passed++;
    run_sequence(1'b1, 1'b0, "b2b");
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    bus.sel_req = 1'b1;
    bus.sel_target = 1'b1;
    step();
    bus.sel_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    total++; if (bus.clk_en !== 1'b1) $display("FAIL rst_e3_clk_en got %b want 1", bus.clk_en); else passed++;
    total++; if (bus.mux_sel !== 1'b0) $display("FAIL rst_e3_mux_sel got %b want 0", bus.mux_sel); else passed++;
    total++; if (bus.sel_busy !== 1'b0) $display("FAIL rst_e3_busy got %b want 0", bus.sel_busy); else passed++;
    rst_n = 1'b1;
    step();
    bus.sel_req = 1'b1;
    step();
    bus.sel_req = 1'b0;
    repeat (7) step();
    total++; if (bus.mux_sel !== 1'b1) $display("FAIL rst_e7_pre_mux_sel got %b want 1", bus.mux_sel); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.mux_sel !== 1'b0) $display("FAIL rst_e7_mux_sel got %b want 0", bus.mux_sel); else passed++;
    total++; if (bus.clk_en !== 1'b1) $display("FAIL rst_e7_clk_en got %b want 1", bus.clk_en); else passed++;
    rst_n = 1'b1;
    step();
    total++; if (bus.sel_busy !== 1'b0) $display("FAIL rst_e7_idle_busy got %b want 0", bus.sel_busy); else passed++;
  endtask

`ifdef AIBND_CLKSEL_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.sel_lock = 1'b1;
    bus.sel_req = 1'b1;
    bus.sel_target = 1'b1;
    step();
    bus.sel_req = 1'b0;
    total++; if (bus.sel_err !== 1'b1) $display("FAIL lock_err got %b want 1", bus.sel_err); else passed++;
    total++; if (bus.sel_done !== 1'b0) $display("FAIL lock_done got %b want 0", bus.sel_done); else passed++;
    total++; if (bus.clk_en !== 1'b1) $display("FAIL lock_clk_en got %b want 1", bus.clk_en); else passed++;
    step();
    total++; if (bus.sel_err !== 1'b0) $display("FAIL lock_err_clear got %b want 0", bus.sel_err); else passed++;
    total++; if (bus.mux_sel !== 1'b0) $display("FAIL lock_mux_sel got %b want 0", bus.mux_sel); else passed++;
    bus.sel_lock = 1'b0;
    bus.sel_req = 1'b1;
    step();
    bus.sel_req = 1'b0;
    repeat (2) step();
    bus.sel_lock = 1'b1;
    repeat (11) step();
    total++; if (bus.sel_done !== 1'b1) $display("FAIL lock_mid_done got %b want 1", bus.sel_done); else passed++;
    total++; if (bus.mux_sel !== 1'b1) $display("FAIL lock_mid_mux_sel got %b want 1", bus.mux_sel); else passed++;
    total++; if (bus.sel_err !== 1'b0) $display("FAIL lock_mid_err got %b want 0", bus.sel_err); else passed++;
    bus.sel_lock = 1'b0;
  endtask
`endif

  initial begin
    bus.sel_req = 1'b0;
    bus.sel_target = 1'b0;
`ifdef AIBND_CLKSEL_LOCK_EN
    bus.sel_lock = 1'b0;
`endif
    test_reset();
    test_switch();
    test_noop();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_mid_sequence();
`ifdef AIBND_CLKSEL_LOCK_EN
    test_lock();
`endif
    total++; if (inv_viol !== 0) $display("FAIL final_invariant got %0d want 0", inv_viol); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
